frame_mm_master: RTL

Avalon-MM initiator that pairs with the DDR3 memory responder in the LPC datapath. It captures one frame of FRAME_LEN signed 16-bit samples from an input stream and writes them to consecutive memory words starting at BASE_ADDR. It then reads the same frame back and emits it as an output stream for the LPC analysis stage. It honours the responder's waitrequest and tracks the variable readdatavalid latency.

---
 rtl/frame_mm_master_pkg.sv | 11 +
 rtl/frame_mm_master.sv | 100 ++++++++++
 2 files changed

// File: rtl/frame_mm_master_pkg.sv
// frame_mm_master_pkg: state encodings and default bus widths shared with the memory responder model.
package frame_mm_master_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
endpackage

// File: rtl/frame_mm_master.sv
// frame_mm_master: writes one input frame to memory, reads it back and streams it out.
module frame_mm_master
  import frame_mm_master_pkg::*;
#(
  parameter int FRAME_LEN = 160,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     frame_done,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     out_last,
  output logic        [ADDR_W-1:0] ddr_addr,
  output logic                     ddr_read,
  output logic                     ddr_write,
  output logic signed [DATA_W-1:0] ddr_writedata,
  input  logic signed [DATA_W-1:0] ddr_readdata,
  input  logic                     ddr_readdatavalid,
  input  logic                     ddr_waitrequest
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] FULL = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  state_t r_state, w_next;
  logic [CW-1:0] r_wr_cnt, r_rd_cnt, r_ret_cnt;
  logic w_accept, w_wr_done, w_rd_ack, w_rd_done, w_ret, w_ret_last;
  assign busy       = r_state != IDLE;
  assign in_ready   = (r_state == WRITE) && (r_wr_cnt < FULL) && (!ddr_write || !ddr_waitrequest);
  assign w_accept   = in_valid && in_ready;
  // the final write is the one accepted once every sample has been loaded
  assign w_wr_done  = (r_state == WRITE) && ddr_write && !ddr_waitrequest && (r_wr_cnt == FULL);
  assign w_rd_ack   = (r_state == READ) && ddr_read && !ddr_waitrequest;
  assign w_rd_done  = w_rd_ack && (r_rd_cnt == LAST);
  assign w_ret      = ddr_readdatavalid && ((r_state == READ) || (r_state == DRAIN));
  assign w_ret_last = w_ret && (r_ret_cnt == LAST);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = start ? WRITE : IDLE;
      WRITE: w_next = w_wr_done ? READ : WRITE;
      READ:  w_next = w_rd_done ? DRAIN : READ;
      DRAIN: w_next = w_ret_last ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_cnt      <= '0;
      r_rd_cnt      <= '0;
      r_ret_cnt     <= '0;
      ddr_addr      <= '0;
      ddr_read      <= 1'b0;
      ddr_write     <= 1'b0;
      ddr_writedata <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      out_valid  <= w_ret;
      out_last   <= w_ret_last;
      frame_done <= w_ret_last;
      if (w_ret) begin
        out_data  <= ddr_readdata;
        r_ret_cnt <= r_ret_cnt + CW'(1);
      end
      if (r_state == IDLE && start) begin
        r_wr_cnt  <= '0;
        r_rd_cnt  <= '0;
        r_ret_cnt <= '0;
      end
      if (w_accept) begin
        ddr_write     <= 1'b1;
        ddr_addr      <= BASE + ADDR_W'(r_wr_cnt);
        ddr_writedata <= in_data;
        r_wr_cnt      <= r_wr_cnt + CW'(1);
      end else if (ddr_write && !ddr_waitrequest) ddr_write <= 1'b0;
      if (w_wr_done) begin
        ddr_read <= 1'b1;
        ddr_addr <= BASE + ADDR_W'(r_rd_cnt);
      end
      if (w_rd_ack) begin
        ddr_read <= !w_rd_done;
        ddr_addr <= BASE + ADDR_W'(r_rd_cnt + CW'(1));
        r_rd_cnt <= r_rd_cnt + CW'(1);
      end
    end
  end
endmodule
